// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle for the AES-128 round sequencer.
// The slave modport is the controller; the master modport is the
// surrounding datapath/system that feeds blocks and consumes strobes.
// Optional build macro: AES_CTRL_INV_EN adds the dec / dec_mode signals.
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       load;
    logic       run_en;
    logic       mix_en;
    logic [3:0] round;
    logic [7:0] rcon;
    logic       busy;
`ifdef AES_CTRL_INV_EN
    logic       dec;
    logic       dec_mode;
`endif

    modport master (
        output in_valid, out_ready,
`ifdef AES_CTRL_INV_EN
        output dec,
        input  dec_mode,
`endif
        input  in_ready, out_valid, load, run_en, mix_en, round, rcon, busy
    );

    modport slave (
        input  in_valid, out_ready,
`ifdef AES_CTRL_INV_EN
        input  dec,
        output dec_mode,
`endif
        output in_ready, out_valid, load, run_en, mix_en, round, rcon, busy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 core: one block per handshake,
// initial AddRoundKey on load, then rounds 1..10 with Rcon generation.
// Optional build macro: AES_CTRL_INV_EN enables decrypt mode (inverse Rcon
// sequence starting at 0x36, dec latched into dec_mode on accept).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a block; load fires combinationally on accept
//   RUN   | rounds 1..10, one per cycle; run_en high, round/rcon valid
//   DONE  | ciphertext final in state register; hold until out_ready
module aes_round_ctrl (
    input  logic             clk,
    input  logic             rst,
    aes_round_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q,  rcon_d;
    logic       accept;
`ifdef AES_CTRL_INV_EN
    logic       dec_q, dec_d;
`endif

    // Multiply by x in GF(2^8): next forward Rcon.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef AES_CTRL_INV_EN
    // Divide by x in GF(2^8): next Rcon when walking the key schedule backwards.
    function automatic logic [7:0] inv_xtime(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? 8'h8d : 8'h00);
    endfunction
`endif

    // Reset overrides a coincident in_valid so no load leaks out during reset.
    assign accept = bus.in_valid & (state_q == IDLE) & ~rst;

    // State, round counter and Rcon registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            rcon_q  <= 8'h00;
`ifdef AES_CTRL_INV_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
`ifdef AES_CTRL_INV_EN
            dec_q   <= dec_d;
`endif
        end
    end

    // Next-state, round and Rcon sequencing.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
`ifdef AES_CTRL_INV_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            IDLE: begin
                round_d = 4'd0;
                rcon_d  = 8'h00;
                if (accept) begin
                    state_d = RUN;
                    round_d = 4'd1;
`ifdef AES_CTRL_INV_EN
                    dec_d   = bus.dec;
                    rcon_d  = bus.dec ? 8'h36 : 8'h01;
`else
                    rcon_d  = 8'h01;
`endif
                end
            end
            RUN: begin
                if (round_q == LAST_ROUND) begin
                    state_d = DONE;
                    round_d = 4'd0;
                    rcon_d  = 8'h00;
                end else begin
                    round_d = round_q + 4'd1;
`ifdef AES_CTRL_INV_EN
                    rcon_d  = dec_q ? inv_xtime(rcon_q) : xtime(rcon_q);
`else
                    rcon_d  = xtime(rcon_q);
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = 4'd0;
                rcon_d  = 8'h00;
            end
        endcase
    end

    // Strobes decode from registered state; load is the sole input-driven path.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.busy      = (state_q == RUN) || (state_q == DONE);
        bus.run_en    = (state_q == RUN);
        bus.out_valid = (state_q == DONE);
        bus.mix_en    = (state_q == RUN) && (round_q != LAST_ROUND);
        bus.load      = accept;
        bus.round     = round_q;
        bus.rcon      = rcon_q;
`ifdef AES_CTRL_INV_EN
        bus.dec_mode  = dec_q;
`endif
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: a cycle-position model of the
// block lifecycle is compared with the DUT every cycle, and directed
// sequences pin specific literal values.
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_round_ctrl_if bus();

    aes_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;
    int cyc = 0;
    int load_times[$];
    int ov_seen = 0;

    logic [7:0] rcon_fwd [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [7:0] rcon_inv [10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                  8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    // Model: position of the block in flight. 0 = idle, 1..10 = round, 11 = done.
    int m_pos = 0;
    bit m_dec = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model advance on each rising edge, from the inputs present at that edge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_pos = 0;
            m_dec = 1'b0;
        end else if (m_pos == 0) begin
            if (bus.in_valid) begin
                m_pos = 1;
`ifdef AES_CTRL_INV_EN
                m_dec = bus.dec;
`endif
            end
        end else if (m_pos <= 10) begin
            m_pos++;
        end else if (bus.out_ready) begin
            m_pos = 0;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            bit         e_idle, e_run, e_done;
            logic [7:0] e_rcon;
            int         nstrobe;
            e_idle = (m_pos == 0);
            e_run  = (m_pos >= 1) && (m_pos <= 10);
            e_done = (m_pos == 11);
            e_rcon = e_run ? (m_dec ? rcon_inv[m_pos-1] : rcon_fwd[m_pos-1]) : 8'h00;
            chk("in_ready",  bus.in_ready,  e_idle);
            chk("busy",      bus.busy,      e_run | e_done);
            chk("run_en",    bus.run_en,    e_run);
            chk("out_valid", bus.out_valid, e_done);
            chk("mix_en",    bus.mix_en,    e_run && (m_pos != 10));
            chk("load",      bus.load,      e_idle && bus.in_valid && !rst);
            chk("round",     bus.round,     e_run ? m_pos : 0);
            chk("rcon",      bus.rcon,      e_rcon);
`ifdef AES_CTRL_INV_EN
            chk("dec_mode",  bus.dec_mode,  m_dec);
`endif
            nstrobe = int'(bus.load) + int'(bus.run_en) + int'(bus.out_valid);
            chk("strobe_exclusive", nstrobe <= 1, 1);
            if (bus.load === 1'b1) load_times.push_back(cyc);
            if (bus.out_valid === 1'b1) ov_seen++;
        end
    end

    task automatic wait_out_valid(input int budget, output int cnt);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < budget) begin
            tick();
            cnt++;
        end
        if (bus.out_valid !== 1'b1) chk("wait_out_valid_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int start_idx;
        int ov_before;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
`ifdef AES_CTRL_INV_EN
        bus.dec = 1'b0;
`endif
        tick();
        check_en = 1'b1;
        tick();
        rst = 1'b0;

        // Reset then idle
        repeat (5) tick();
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_busy",     bus.busy,     0);
        chk("idle_round",    bus.round,    0);
        chk("idle_rcon",     bus.rcon,     8'h00);
        chk("idle_strobes",  {bus.load, bus.run_en, bus.out_valid, bus.mix_en}, 4'b0000);

        // Single block with out_ready=1
        bus.in_valid = 1'b1;
        #1;
        chk("single_load", bus.load, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("single_round1", bus.round, 1);
        chk("single_rcon1",  bus.rcon,  8'h01);
        repeat (8) tick();
        chk("single_rcon9",  bus.rcon,  8'h1b);
        chk("single_mix9",   bus.mix_en, 1);
        tick();
        chk("single_round10", bus.round, 10);
        chk("single_rcon10",  bus.rcon,  8'h36);
        chk("single_mix10",   bus.mix_en, 0);
        chk("single_run10",   bus.run_en, 1);
        tick();
        chk("single_out_valid_T11", bus.out_valid, 1);
        tick();
        chk("single_in_ready_T12", bus.in_ready, 1);

        // Backpressure: hold DONE for 20 cycles with in_valid pulses
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        wait_out_valid(20, cnt);
        chk("bp_latency", cnt, 10);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            #1;
            chk("bp_no_load", bus.load, 0);
            tick();
        end
        chk("bp_out_valid_held", bus.out_valid, 1);
        chk("bp_in_ready_low",   bus.in_ready,  0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_released_idle", bus.in_ready, 1);
        chk("bp_released_ov",   bus.out_valid, 0);

        // Continuous in_valid: one accept every 12 cycles
        start_idx = load_times.size();
        bus.in_valid = 1'b1;
        repeat (40) tick();
        bus.in_valid = 1'b0;
        repeat (15) tick();
        chk("cont_accepts", load_times.size() - start_idx, 4);
        for (int i = start_idx + 1; i < load_times.size(); i++)
            chk("cont_interval", load_times[i] - load_times[i-1], 12);

        // Reset mid-operation at round 5
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_round5", bus.round, 5);
        ov_before = ov_seen;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk("mid_rst_no_load", bus.load, 0);
        tick();
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_round",    bus.round,    0);
        chk("rst_idle_in_valid_no_load", bus.load, 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (15) tick();
        chk("mid_no_out_valid", ov_seen - ov_before, 0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cnt = 0;
        wait_out_valid(30, cnt);
        chk("mid_new_block_latency", cnt + 1, 11);
        tick();

`ifdef AES_CTRL_INV_EN
        // Decrypt: inverse Rcon sequence and dec_mode latching
        bus.dec = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.dec = 1'b0;
        chk("inv_rcon1", bus.rcon, 8'h36);
        chk("inv_dec_mode", bus.dec_mode, 1);
        tick();
        chk("inv_rcon2", bus.rcon, 8'h1b);
        tick();
        chk("inv_rcon3", bus.rcon, 8'h80);
        wait_out_valid(20, cnt);
        tick();
        repeat (3) tick();
        chk("inv_dec_mode_held", bus.dec_mode, 1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("inv_dec_mode_cleared", bus.dec_mode, 0);
        chk("inv_fwd_rcon1", bus.rcon, 8'h01);
        wait_out_valid(20, cnt);
        tick();
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the iterative AES-128 core. Accepts one block per valid/ready handshake, walks the shared round datapath (state register, 128-bit round-key register, key-expansion logic) through the initial AddRoundKey plus rounds 1–10, and presents the finished block with a valid/ready handshake. It drives the load/enable strobes, round number and Rcon byte that the key register and round logic consume.

## Interface
- No parameters; round count fixed at 10 (AES-128).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext and key present on datapath inputs
- in_ready  out  1  controller can accept a block
- out_valid  out  1  ciphertext in state register is final
- out_ready  in  1  consumer takes the block
- load  out  1  capture external plaintext^key into state register and external key into key register
- run_en  out  1  state register and key register update from round logic this cycle
- mix_en  out  1  MixColumns included in this round (0 in round 10)
- round  out  4  current round number, 0–10
- rcon  out  8  Rcon byte for the key expansion producing this round's key
- busy  out  1  block in flight (RUN or DONE)
- dec  in  1  decrypt request, sampled on accept (present only with AES_CTRL_INV_EN)
- dec_mode  out  1  latched decrypt flag (present only with AES_CTRL_INV_EN)

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. Accept = in_valid & in_ready. On accept: load=1 in the same cycle (combinational from in_valid); round←1; rcon←0x01; go to RUN. No accept: remain, round=0, rcon=0x00.
- RUN: run_en=1 every cycle. mix_en=1 for round 1–9, 0 for round 10. rcon follows 01,02,04,08,10,20,40,80,1B,36 for round 1..10, generated by xtime of the previous value: shift left, XOR 0x1B on carry-out. When round=10: round←0, rcon←0x00, go to DONE. Otherwise round←round+1.
- DONE: out_valid=1, run_en=0. When out_ready=1: go to IDLE. Hold indefinitely while out_ready=0. The state register must not change while in DONE.
- in_ready=0 in RUN and DONE. in_valid is ignored there. No back-to-back accept from DONE; the next block is accepted no earlier than the first IDLE cycle.
- busy=1 in RUN and DONE.
- load, run_en and out_valid are mutually exclusive in every cycle.
- round/rcon/state are registers. in_ready, out_valid, run_en, mix_en and busy decode from registered state only. load is the only input-to-output combinational path.

## Timing
- Reset values: state IDLE, round=0, rcon=0x00, in_ready=1 (the first cycle after rst deasserts), out_valid=0, run_en=0, mix_en=0, load=0, busy=0, dec_mode=0.
- Accept in cycle T. RUN cycles T+1..T+10 (round 1..10). out_valid rises at T+11.
- Minimum block interval: 12 cycles (accept, 10 RUN, 1 DONE with out_ready=1). The next accept happens at T+12.
- rst asserted in any state: the next cycle is IDLE with reset values. An in-flight block is discarded and no out_valid is issued for it.
- rst and in_valid high together: rst wins and load=0.
- round never exceeds 10. round=0 occurs only outside RUN.

## Configuration
- AES_CTRL_INV_EN defined:
  - dec port and dec_mode port exist.
  - dec is latched into dec_mode on accept and held until the next accept. Reset clears it.
  - When dec_mode=1, rcon runs 36,1B,80,40,20,10,08,04,02,01 for round 1..10, for inverse key expansion from the last round key. The value is generated by the inverse xtime: shift right, XOR 0x8D when the LSB is 1, starting at 0x36. mix_en has the same timing (0 in round 10; the datapath selects InvMixColumns).
- AES_CTRL_INV_EN undefined: no dec/dec_mode ports; encrypt-only; forward Rcon sequence only.

## Test plan
- Reset then idle: hold rst 2 cycles, release, in_valid=0 for 5 cycles -> in_ready=1, busy=0, round=0, rcon=0x00, all strobes 0.
- Single block, out_ready=1: in_valid pulse at T -> load=1 at T only; run_en=1 T+1..T+10; rcon 01..36 in order; mix_en=0 only at T+10; out_valid=1 exactly at T+11; in_ready=1 again at T+12.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid stays 1, in_ready=0, in_valid pulses ignored (no load); raise out_ready -> IDLE the next cycle.
- Continuous in_valid=1 with out_ready=1 -> accepts every 12 cycles exactly; load never coincides with run_en or out_valid.
- Reset mid-operation: rst at round 5 -> next cycle IDLE, round=0, out_valid never asserts for that block; a new block afterwards completes in 11 cycles.
- AES_CTRL_INV_EN: accept with dec=1 -> rcon sequence 36,1B,80,40,20,10,08,04,02,01; dec_mode=1 until the next accept with dec=0.
